hazard_scoreboard: RTL and testbench

- Parametrised successor to the single-stage interlock in the ID stage.
- Tracks in-flight register writes with a per-register countdown scoreboard, not fixed EXE/MEM address compares. Stalls on RAW hazards with configurable write-back latency and optional forwarding window.
- Adds branch-flush sequencing and a saturating stall-cycle counter.
- Sits between decode and the ID/EX pipeline register. Gates the PC/IF-ID enable and bubbles control signals.

---
 rtl/hazard_scoreboard.sv | 162 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   RAW interlock between decode and the ID/EX pipeline register. Each
//   architectural register has a countdown holding the number of cycles until
//   its in-flight result is visible (or forwardable). An ID instruction whose
//   source is still pending is held. A taken branch squashes the following
//   FLUSH_CYC ID slots.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   id_valid        ID holds a valid instruction
//   id_ins          instruction word (rs = [25:21], rt = [20:16], opcode = [31:26])
//   id_pc           PC of the ID instruction
//   id_wreg/id_wmem/id_branch/id_load  decoded control
//   id_dst          decoded destination register
//   ex_taken        branch resolved taken in EX (one-cycle pulse)
//   stall           hold PC and IF/ID
//   flush           ID instruction is being squashed
//   pc_out          PC passed on to ID/EX
//   issue           a valid instruction enters ID/EX this cycle
//   wreg_out/wmem_out/branch_out  control gated by issue
//   stall_cnt       saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int AW        = 5,
  parameter int PC_W      = 32,
  parameter int WB_LAT    = 3,
  parameter int LD_EXTRA  = 1,
  parameter int FWD_EN    = 0,
  parameter int FWD_LAT   = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_ins,
  input  logic [PC_W-1:0] id_pc,
  input  logic            id_wreg,
  input  logic            id_wmem,
  input  logic            id_branch,
  input  logic            id_load,
  input  logic [AW-1:0]   id_dst,
  input  logic            ex_taken,
  output logic            stall,
  output logic            flush,
  output logic [PC_W-1:0] pc_out,
  output logic            issue,
  output logic            wreg_out,
  output logic            wmem_out,
  output logic            branch_out,
  output logic [15:0]     stall_cnt
);

  localparam int SbW    = $clog2(WB_LAT + LD_EXTRA + 1);
  localparam int NumReg = 1 << AW;

  localparam logic [SbW-1:0] AluLat    = SbW'(WB_LAT);
  localparam logic [SbW-1:0] LoadLat   = SbW'(WB_LAT + LD_EXTRA);
  localparam logic [SbW-1:0] FwdThresh = SbW'(FWD_LAT);
  localparam logic [SbW-1:0] SbZero    = SbW'(0);
  localparam logic [SbW-1:0] SbOne     = SbW'(1);
  localparam logic [2:0]     FlushLoad = 3'(FLUSH_CYC);

  logic [SbW-1:0] sbCnt_r [NumReg];
  logic [2:0]     flushCnt_r;
  logic [15:0]    stallCnt_r;

  logic [AW-1:0]  rsIdx_s;
  logic [AW-1:0]  rtIdx_s;
  logic           rtUsed_s;
  logic           hazard_s;
  logic           sbSet_s;
  logic [SbW-1:0] sbSetVal_s;
  logic           unusedIns_s;

  // A source blocks while its result is neither written back nor, with
  // forwarding, close enough to be bypassed.
  function automatic logic srcBlocked(input logic [SbW-1:0] cnt);
    if (FWD_EN != 0) begin
      srcBlocked = (cnt > FwdThresh);
    end else begin
      srcBlocked = (cnt != SbZero);
    end
  endfunction

  assign rsIdx_s     = AW'(id_ins[25:21]);
  assign rtIdx_s     = AW'(id_ins[20:16]);
  assign unusedIns_s = ^id_ins[15:0];

  // Decode which sources are read and look them up in the scoreboard.
  always_comb begin
    rtUsed_s = 1'b0;
    hazard_s = 1'b0;
    case (id_ins[31:26])
      6'b000000, 6'b101011, 6'b000100, 6'b000101: rtUsed_s = 1'b1;
      default:                                    rtUsed_s = 1'b0;
    endcase
    if ((rsIdx_s != {AW{1'b0}}) && srcBlocked(sbCnt_r[rsIdx_s])) begin
      hazard_s = 1'b1;
    end else if (rtUsed_s && (rtIdx_s != {AW{1'b0}}) && srcBlocked(sbCnt_r[rtIdx_s])) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Flush wins over stall: a squashed slot neither stalls nor issues.
  assign flush      = (flushCnt_r != 3'd0);
  assign stall      = id_valid & hazard_s & ~flush;
  assign issue      = id_valid & ~stall & ~flush;
  assign wreg_out   = id_wreg & issue;
  assign wmem_out   = id_wmem & issue;
  assign branch_out = id_branch & issue;
  assign pc_out     = id_pc;
  assign stall_cnt  = stallCnt_r;

  assign sbSet_s    = issue & id_wreg & (id_dst != {AW{1'b0}});
  assign sbSetVal_s = id_load ? LoadLat : AluLat;

  // Per-register countdown; an issuing write reloads its destination, which
  // takes precedence over that register's decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NumReg; r++) begin
        sbCnt_r[r] <= SbZero;
      end
    end else begin
      for (int r = 0; r < NumReg; r++) begin
        if (sbSet_s && (id_dst == AW'(r))) begin
          sbCnt_r[r] <= sbSetVal_s;
        end else if (sbCnt_r[r] != SbZero) begin
          sbCnt_r[r] <= sbCnt_r[r] - SbOne;
        end else begin
          sbCnt_r[r] <= sbCnt_r[r];
        end
      end
    end
  end

  // Branch squash window; a new taken branch restarts the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushCnt_r <= 3'd0;
    end else if (ex_taken) begin
      flushCnt_r <= FlushLoad;
    end else if (flushCnt_r != 3'd0) begin
      flushCnt_r <= flushCnt_r - 3'd1;
    end else begin
      flushCnt_r <= flushCnt_r;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_r <= 16'd0;
    end else if (stall && (stallCnt_r != 16'hFFFF)) begin
      stallCnt_r <= stallCnt_r + 16'd1;
    end else begin
      stallCnt_r <= stallCnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. Three instances share one input stream:
//   dutA: defaults (WB_LAT=3, LD_EXTRA=1, FWD_EN=0, FWD_LAT=2, FLUSH_CYC=2)
//   dutB: as dutA but FWD_EN=1
//   dutC: WB_LAT=255, LD_EXTRA=0 (long stalls to reach counter saturation)
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_ins;
  logic [31:0] id_pc;
  logic        id_wreg, id_wmem, id_branch, id_load;
  logic [4:0]  id_dst;
  logic        ex_taken;

  logic        stallA, flushA, issueA, wregA, wmemA, branchA;
  logic [31:0] pcOutA;
  logic [15:0] stallCntA;
  logic        stallB, flushB, issueB, wregB, wmemB, branchB;
  logic [31:0] pcOutB;
  logic [15:0] stallCntB;
  logic        stallC, flushC, issueC, wregC, wmemC, branchC;
  logic [31:0] pcOutC;
  logic [15:0] stallCntC;

  hazard_scoreboard dutA (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ins(id_ins), .id_pc(id_pc),
    .id_wreg(id_wreg), .id_wmem(id_wmem), .id_branch(id_branch), .id_load(id_load),
    .id_dst(id_dst), .ex_taken(ex_taken), .stall(stallA), .flush(flushA),
    .pc_out(pcOutA), .issue(issueA), .wreg_out(wregA), .wmem_out(wmemA),
    .branch_out(branchA), .stall_cnt(stallCntA));

  hazard_scoreboard #(.FWD_EN(1)) dutB (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ins(id_ins), .id_pc(id_pc),
    .id_wreg(id_wreg), .id_wmem(id_wmem), .id_branch(id_branch), .id_load(id_load),
    .id_dst(id_dst), .ex_taken(ex_taken), .stall(stallB), .flush(flushB),
    .pc_out(pcOutB), .issue(issueB), .wreg_out(wregB), .wmem_out(wmemB),
    .branch_out(branchB), .stall_cnt(stallCntB));

  hazard_scoreboard #(.WB_LAT(255), .LD_EXTRA(0)) dutC (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ins(id_ins), .id_pc(id_pc),
    .id_wreg(id_wreg), .id_wmem(id_wmem), .id_branch(id_branch), .id_load(id_load),
    .id_dst(id_dst), .ex_taken(ex_taken), .stall(stallC), .flush(flushC),
    .pc_out(pcOutC), .issue(issueC), .wreg_out(wregC), .wmem_out(wmemC),
    .branch_out(branchC), .stall_cnt(stallCntC));

  // dutA control bundle: {stall, issue, flush, wreg_out, wmem_out, branch_out}
  logic [5:0] obsA;
  assign obsA = {stallA, issueA, flushA, wregA, wmemA, branchA};

  typedef struct packed {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        wr;
    logic        wm;
    logic        br;
    logic        ld;
    logic [4:0]  dst;
    logic        tk;
  } stimT;

  typedef struct packed {
    logic [5:0]  a;     // expected dutA control bundle
    logic        chkB;  // also check dutB
    logic [1:0]  b;     // expected {stallB, issueB}
    logic [31:0] pc;
  } expT;

  stimT stimQ[$];
  expT  expQ[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  function automatic logic [31:0] mkIns(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    mkIns = {op, rs, rt, 16'h0820};
  endfunction

  function automatic stimT mkStim(input logic v, input logic [31:0] ins, input logic wr, input logic wm,
                                  input logic br, input logic ld, input logic [4:0] dst, input logic tk);
    stimT s;
    s.v = v; s.ins = ins; s.pc = $urandom; s.wr = wr; s.wm = wm;
    s.br = br; s.ld = ld; s.dst = dst; s.tk = tk;
    mkStim = s;
  endfunction

  // Queue one cycle of stimulus together with its expected outcome.
  task automatic addRow(input stimT s, input logic [5:0] a, input logic chkB, input logic [1:0] b);
    expT e;
    e.a = a; e.chkB = chkB; e.b = b; e.pc = s.pc;
    stimQ.push_back(s);
    expQ.push_back(e);
  endtask

  task automatic applyStim(input stimT s);
    @(negedge clk);
    id_valid = s.v; id_ins = s.ins; id_pc = s.pc; id_wreg = s.wr; id_wmem = s.wm;
    id_branch = s.br; id_load = s.ld; id_dst = s.dst; ex_taken = s.tk;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; id_valid = 1'b0; ex_taken = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStim(mkStim(1'b1, mkIns(OP_R, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0));
    #1;
    checks++; if (obsA !== 6'b010100) begin errors++; $display("FAIL reset_ctl got %b want %b", obsA, 6'b010100); end
    checks++; if (pcOutA !== id_pc) begin errors++; $display("FAIL reset_pc got %h want %h", pcOutA, id_pc); end
    checks++; if (stallCntA !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stallCntA); end
    rst_n = 1'b1;
    // Reset while stalled on $8.
    applyStim(mkStim(1'b1, mkIns(OP_R, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0));
    applyStim(mkStim(1'b1, mkIns(OP_R, 5'd8, 5'd3), 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0));
    applyStim(mkStim(1'b1, mkIns(OP_R, 5'd8, 5'd3), 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0));
    #1;
    checks++; if ({stallA, stallCntA} !== {1'b1, 16'd1}) begin errors++; $display("FAIL midstall_pre got stall=%b cnt=%0d want stall=1 cnt=1", stallA, stallCntA); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (obsA !== 6'b010100) begin errors++; $display("FAIL midstall_rst_ctl got %b want %b", obsA, 6'b010100); end
    checks++; if (stallCntA !== 16'd0) begin errors++; $display("FAIL midstall_rst_cnt got %0d want 0", stallCntA); end
    checks++; if ({stallB, stallC} !== 2'b00) begin errors++; $display("FAIL midstall_rst_bc got %b want 00", {stallB, stallC}); end
    rst_n = 1'b1;
    #1;
    checks++; if (issueA !== 1'b1) begin errors++; $display("FAIL midstall_release got issue=%b want 1", issueA); end
    // Reset while flushing.
    doReset();
    applyStim(mkStim(1'b1, mkIns(OP_R, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1));
    applyStim(mkStim(1'b1, mkIns(OP_R, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    #1;
    checks++; if (flushA !== 1'b1) begin errors++; $display("FAIL midflush_pre got flush=%b want 1", flushA); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({flushA, issueA} !== 2'b01) begin errors++; $display("FAIL midflush_rst got flush,issue=%b want 01", {flushA, issueA}); end
    rst_n = 1'b1;
  endtask

  task automatic test_raw_alu();
    stimT s; expT e; int i;
    doReset();
    addRow(mkStim(1'b1, mkIns(OP_R, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0), 6'b010100, 1'b0, 2'b00);
    for (int k = 0; k < 4; k++) begin
      addRow(mkStim(1'b1, mkIns(OP_R, 5'd8, 5'd3), 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0),
             (k < 3) ? 6'b100000 : 6'b010100, 1'b0, 2'b00);
    end
    i = 0;
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front(); applyStim(s); #1; e = expQ.pop_front();
      checks++; if (obsA !== e.a) begin errors++; $display("FAIL raw_alu row%0d got %b want %b", i, obsA, e.a); end
      checks++; if (pcOutA !== e.pc) begin errors++; $display("FAIL raw_alu_pc row%0d got %h want %h", i, pcOutA, e.pc); end
      i++;
    end
    checks++; if (stallCntA !== 16'd3) begin errors++; $display("FAIL raw_alu_cnt got %0d want 3", stallCntA); end
  endtask

  task automatic test_load_use();
    stimT s; expT e; int i;
    doReset();
    addRow(mkStim(1'b1, mkIns(OP_LW, 5'd1, 5'd9), 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0), 6'b010100, 1'b1, 2'b01);
    for (int k = 1; k <= 5; k++) begin
      addRow(mkStim(1'b1, mkIns(OP_R, 5'd2, 5'd9), 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0),
             (k < 5) ? 6'b100000 : 6'b010100, 1'b1, (k < 3) ? 2'b10 : 2'b01);
    end
    i = 0;
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front(); applyStim(s); #1; e = expQ.pop_front();
      checks++; if (obsA !== e.a) begin errors++; $display("FAIL load_use_A row%0d got %b want %b", i, obsA, e.a); end
      if (e.chkB) begin
        checks++; if ({stallB, issueB} !== e.b) begin errors++; $display("FAIL load_use_B row%0d got %b want %b", i, {stallB, issueB}, e.b); end
      end
      i++;
    end
    checks++; if ({stallCntA, stallCntB} !== {16'd4, 16'd2}) begin errors++; $display("FAIL load_use_cnt got %0d/%0d want 4/2", stallCntA, stallCntB); end
  endtask

  task automatic test_rt_decode();
    stimT s; expT e; int i;
    for (int k = 0; k < 2; k++) begin
      doReset();
      addRow(mkStim(1'b1, mkIns(OP_R, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0), 6'b010100, 1'b1, 2'b01);
      addRow(mkStim(1'b0, mkIns(OP_R, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0), 6'b000000, 1'b1, 2'b00);
      if (k == 0) begin
        addRow(mkStim(1'b1, mkIns(OP_ADDI, 5'd1, 5'd8), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0), 6'b010000, 1'b1, 2'b01);
      end else begin
        addRow(mkStim(1'b1, mkIns(OP_SW, 5'd1, 5'd8), 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0), 6'b100000, 1'b1, 2'b01);
        addRow(mkStim(1'b1, mkIns(OP_SW, 5'd1, 5'd8), 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0), 6'b100000, 1'b1, 2'b01);
        addRow(mkStim(1'b1, mkIns(OP_SW, 5'd1, 5'd8), 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0), 6'b010010, 1'b1, 2'b01);
      end
      i = 0;
      while (stimQ.size() > 0) begin
        s = stimQ.pop_front(); applyStim(s); #1; e = expQ.pop_front();
        checks++; if (obsA !== e.a) begin errors++; $display("FAIL rt_decode%0d_A row%0d got %b want %b", k, i, obsA, e.a); end
        checks++; if ({stallB, issueB} !== e.b) begin errors++; $display("FAIL rt_decode%0d_B row%0d got %b want %b", k, i, {stallB, issueB}, e.b); end
        i++;
      end
    end
  endtask

  task automatic test_flush();
    stimT s; expT e; int i;
    logic [31:0] x;
    doReset();
    x = mkIns(OP_R, 5'd8, 5'd3);
    addRow(mkStim(1'b1, mkIns(OP_R, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0), 6'b010100, 1'b0, 2'b00);
    addRow(mkStim(1'b1, x, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1), 6'b100000, 1'b0, 2'b00);
    addRow(mkStim(1'b1, x, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 1'b0), 6'b001000, 1'b0, 2'b00);
    addRow(mkStim(1'b1, x, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 1'b0), 6'b001000, 1'b0, 2'b00);
    // Reads $12: stalls only if a squashed slot wrote the scoreboard.
    addRow(mkStim(1'b1, mkIns(OP_BEQ, 5'd12, 5'd8), 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0), 6'b010001, 1'b0, 2'b00);
    i = 0;
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front(); applyStim(s); #1; e = expQ.pop_front();
      checks++; if (obsA !== e.a) begin errors++; $display("FAIL flush row%0d got %b want %b", i, obsA, e.a); end
      i++;
    end
    checks++; if (stallCntA !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d want 1", stallCntA); end
    doReset();
    x = mkIns(OP_R, 5'd1, 5'd2);
    addRow(mkStim(1'b1, x, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1), 6'b010001, 1'b0, 2'b00);
    addRow(mkStim(1'b1, x, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1), 6'b001000, 1'b0, 2'b00);
    addRow(mkStim(1'b1, x, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0), 6'b001000, 1'b0, 2'b00);
    addRow(mkStim(1'b1, x, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0), 6'b001000, 1'b0, 2'b00);
    addRow(mkStim(1'b1, x, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0), 6'b010001, 1'b0, 2'b00);
    i = 0;
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front(); applyStim(s); #1; e = expQ.pop_front();
      checks++; if (obsA !== e.a) begin errors++; $display("FAIL reflush row%0d got %b want %b", i, obsA, e.a); end
      i++;
    end
  endtask

  task automatic test_reg0();
    stimT s; expT e; int i;
    doReset();
    addRow(mkStim(1'b1, mkIns(OP_R, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0), 6'b010100, 1'b1, 2'b01);
    addRow(mkStim(1'b1, mkIns(OP_R, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0), 6'b010100, 1'b1, 2'b01);
    addRow(mkStim(1'b1, mkIns(OP_SW, 5'd0, 5'd0), 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0), 6'b010010, 1'b1, 2'b01);
    i = 0;
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front(); applyStim(s); #1; e = expQ.pop_front();
      checks++; if (obsA !== e.a) begin errors++; $display("FAIL reg0_A row%0d got %b want %b", i, obsA, e.a); end
      checks++; if ({stallB, issueB, stallC} !== {e.b, 1'b0}) begin errors++; $display("FAIL reg0_BC row%0d got %b want %b", i, {stallB, issueB, stallC}, {e.b, 1'b0}); end
      i++;
    end
    checks++; if (stallCntA !== 16'd0) begin errors++; $display("FAIL reg0_cnt got %0d want 0", stallCntA); end
  endtask

  // dutC: an instruction reading and writing $5 held in ID issues once per
  // 256 cycles and stalls the other 255.
  task automatic test_saturation();
    stimT s;
    doReset();
    s = mkStim(1'b1, mkIns(OP_R, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0);
    for (int c = 0; c <= 256; c++) begin
      applyStim(s);
      #1;
      if (c == 1) begin
        checks++; if ({stallC, issueC} !== 2'b10) begin errors++; $display("FAIL sat_first_stall got %b want 10", {stallC, issueC}); end
      end
      if (c == 256) begin
        checks++; if ({stallC, issueC, stallCntC} !== {2'b01, 16'd255}) begin errors++; $display("FAIL sat_period got stall,issue=%b cnt=%0d want 01 cnt=255", {stallC, issueC}, stallCntC); end
      end
    end
    for (int c = 0; c < 66000; c++) begin
      applyStim(s);
    end
    #1;
    checks++; if (stallCntC !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", stallCntC); end
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_ins = 32'd0; id_pc = 32'd0; id_wreg = 1'b0;
    id_wmem = 1'b0; id_branch = 1'b0; id_load = 1'b0; id_dst = 5'd0; ex_taken = 1'b0;
    test_reset();
    test_raw_alu();
    test_load_use();
    test_rt_decode();
    test_flush();
    test_reg0();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
